// File: rtl/muldiv_pkg.sv
// Shared definitions for the mul/div issue controller: ALU opcodes,
// RISC-V M-extension funct3 codes and the controller state encoding.
package muldiv_pkg;

    // 5-bit mul/div ALU opcodes understood by alu_muldiv
    localparam logic [4:0] OPC_NONE   = 5'b00000;
    localparam logic [4:0] OPC_MUL    = 5'b01001;
    localparam logic [4:0] OPC_MULH   = 5'b01010;
    localparam logic [4:0] OPC_MULHSU = 5'b01100;
    localparam logic [4:0] OPC_MULHU  = 5'b01011;
    localparam logic [4:0] OPC_DIV    = 5'b01101;
    localparam logic [4:0] OPC_DIVU   = 5'b01110;
    localparam logic [4:0] OPC_REM    = 5'b01111;
    localparam logic [4:0] OPC_REMU   = 5'b10000;

    // funct3 field of the M-extension instructions
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_opc_enc.sv
// Combinational funct3 -> mul/div ALU opcode encoder. Kept standalone so the
// decode stage can reuse the same mapping.
module muldiv_opc_enc
    import muldiv_pkg::*;
(
    input  logic [2:0] funct3,
    output logic [4:0] opcode
);

    // Full table over all eight funct3 values
    always_comb begin
        opcode = OPC_NONE;
        unique case (funct3)
            F3_MUL:    opcode = OPC_MUL;
            F3_MULH:   opcode = OPC_MULH;
            F3_MULHSU: opcode = OPC_MULHSU;
            F3_MULHU:  opcode = OPC_MULHU;
            F3_DIV:    opcode = OPC_DIV;
            F3_DIVU:   opcode = OPC_DIVU;
            F3_REM:    opcode = OPC_REM;
            F3_REMU:   opcode = OPC_REMU;
        endcase
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Requester-side sequencer for the combinational mul/div unit. Registers the
// operands/opcode, waits LAT settle cycles (multicycle path), captures the
// result and presents it to writeback.
// Optional: define MULDIV_OPERAND_REUSE_EN to shorten an operation to one
// EXEC cycle when rs1/rs2 match the previously accepted operands.
module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int N   = 32,
    parameter int LAT = 2,
    parameter int RW  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_funct3,
    input  logic [N-1:0]  in_rs1,
    input  logic [N-1:0]  in_rs2,
    input  logic [RW-1:0] in_rd,
    output logic [N-1:0]  alu_rega,
    output logic [N-1:0]  alu_regb,
    output logic [4:0]    alu_opcode,
    input  logic [N-1:0]  alu_res_muldiv,
    input  logic          flag_divbyzero,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_dbz,
    output logic          busy
);

    // 4 bits cover the largest legal settle count (LAT-1 = 14)
    localparam int CW = 4;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rega_q, rega_d, regb_q, regb_d;
    logic [4:0]    opc_q, opc_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [N-1:0]  data_q, data_d;
    logic          dbz_q, dbz_d;
    logic          vld_q, vld_d;
    logic [4:0]    enc_opc;
    logic          accept;
    logic          reuse_hit;

    muldiv_opc_enc u_enc (
        .funct3 (in_funct3),
        .opcode (enc_opc)
    );

    // Input side opens in IDLE, or in DONE when writeback drains this cycle
    assign in_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

`ifdef MULDIV_OPERAND_REUSE_EN
    // The operand registers double as the last-accepted rs1/rs2 copy
    logic reuse_vld_q, reuse_vld_d;
    assign reuse_hit   = reuse_vld_q & (in_rs1 == rega_q) & (in_rs2 == regb_q);
    assign reuse_vld_d = reuse_vld_q | accept;

    // Reuse-valid bit survives flush since the operands are not cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reuse_vld_q <= 1'b0;
        else        reuse_vld_q <= reuse_vld_d;
    end
`else
    assign reuse_hit = 1'b0;
`endif

    // Next-state: FSM transitions, settle counter, operand load and capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        opc_d   = opc_q;
        rd_d    = rd_q;
        data_d  = data_q;
        dbz_d   = dbz_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: ;
            EXEC: begin
                if (cnt_q == '0) begin
                    data_d  = alu_res_muldiv;
                    dbz_d   = flag_divbyzero;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Unit inputs only move here, keeping them stable through EXEC
        if (accept) begin
            rega_d  = in_rs1;
            regb_d  = in_rs2;
            opc_d   = enc_opc;
            rd_d    = in_rd;
            cnt_d   = reuse_hit ? '0 : CW'(LAT - 1);
            state_d = EXEC;
        end
        // Kill drops any in-flight or pending result; operands are kept
        if (flush) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rega_q  <= '0;
            regb_q  <= '0;
            opc_q   <= OPC_NONE;
            rd_q    <= '0;
            data_q  <= '0;
            dbz_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            dbz_q   <= dbz_d;
            vld_q   <= vld_d;
        end
    end

    assign alu_rega   = rega_q;
    assign alu_regb   = regb_q;
    assign alu_opcode = opc_q;
    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign out_rd     = rd_q;
    assign out_dbz    = dbz_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Scoreboard bench for muldiv_issue_ctrl with a behavioural mul/div unit.
module tb_muldiv_issue_ctrl;

    localparam int N   = 32;
    localparam int LAT = 2;
    localparam int RW  = 5;
`ifdef MULDIV_OPERAND_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [2:0]    in_funct3;
    logic [N-1:0]  in_rs1, in_rs2;
    logic [RW-1:0] in_rd;
    logic [N-1:0]  alu_rega, alu_regb;
    logic [4:0]    alu_opcode;
    logic [N-1:0]  alu_res_muldiv;
    logic          flag_divbyzero;
    logic          flush;
    logic          out_valid, out_ready;
    logic [N-1:0]  out_data;
    logic [RW-1:0] out_rd;
    logic          out_dbz;
    logic          busy;

    muldiv_issue_ctrl #(.N(N), .LAT(LAT), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .alu_rega(alu_rega), .alu_regb(alu_regb), .alu_opcode(alu_opcode),
        .alu_res_muldiv(alu_res_muldiv), .flag_divbyzero(flag_divbyzero),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_dbz(out_dbz), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural mul/div unit, decoding the opcode table independently
    always_comb begin
        logic signed [63:0] sa, sb, ub;
        logic signed [63:0] p_ss, p_su;
        logic [63:0]        p_uu;
        logic signed [31:0] a_s, b_s;
        sa = {{32{alu_rega[31]}}, alu_rega};
        sb = {{32{alu_regb[31]}}, alu_regb};
        ub = {32'b0, alu_regb};
        p_ss = sa * sb;
        p_su = sa * ub;
        p_uu = {32'b0, alu_rega} * {32'b0, alu_regb};
        a_s = alu_rega;
        b_s = alu_regb;
        alu_res_muldiv = '0;
        flag_divbyzero = 1'b0;
        case (alu_opcode)
            5'b01001: alu_res_muldiv = p_uu[31:0];
            5'b01010: alu_res_muldiv = p_ss[63:32];
            5'b01100: alu_res_muldiv = p_su[63:32];
            5'b01011: alu_res_muldiv = p_uu[63:32];
            5'b01101: begin
                if (alu_regb == 0) alu_res_muldiv = '1;
                else if (alu_rega == 32'h8000_0000 && alu_regb == '1) alu_res_muldiv = alu_rega;
                else alu_res_muldiv = a_s / b_s;
                flag_divbyzero = (alu_regb == 0);
            end
            5'b01110: begin
                alu_res_muldiv = (alu_regb == 0) ? '1 : alu_rega / alu_regb;
                flag_divbyzero = (alu_regb == 0);
            end
            5'b01111: begin
                if (alu_regb == 0) alu_res_muldiv = alu_rega;
                else if (alu_rega == 32'h8000_0000 && alu_regb == '1) alu_res_muldiv = '0;
                else alu_res_muldiv = a_s % b_s;
                flag_divbyzero = (alu_regb == 0);
            end
            5'b10000: begin
                alu_res_muldiv = (alu_regb == 0) ? alu_rega : alu_rega % alu_regb;
                flag_divbyzero = (alu_regb == 0);
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [N-1:0]  data;
        logic [RW-1:0] rd;
        logic          dbz;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   vld_seen = 1'b0;
    bit   have_last = 1'b0;
    logic [N-1:0] last_a, last_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, payload on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (!out_valid) begin
                vld_seen = 1'b0;
            end else if (sbq.size() == 0) begin
                if (!vld_seen) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got out_valid=1 data=0x%0h expected no result", out_data);
                end
                vld_seen = 1'b1;
            end else begin
                if (!vld_seen) begin
                    chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                    vld_seen = 1'b1;
                end
                if (out_ready) begin
                    chk("out_data", 64'(out_data), 64'(sbq[0].data));
                    chk("out_rd", 64'(out_rd), 64'(sbq[0].rd));
                    chk("out_dbz", 64'(out_dbz), 64'(sbq[0].dbz));
                    void'(sbq.pop_front());
                    vld_seen = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction; called and returns at posedge+1
    task automatic issue(input logic [2:0] f3, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [RW-1:0] rd, input logic [N-1:0] exp_d, input logic exp_dbz,
                         input bit want, output bit immediate);
        int   w;
        bit   hit;
        exp_t e;
        w = 0;
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(negedge clk);
        immediate = in_ready;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hit = REUSE && have_last && (a == last_a) && (b == last_b);
        have_last = 1'b1; last_a = a; last_b = b;
        if (want) begin
            e.data = exp_d; e.rd = rd; e.dbz = exp_dbz;
            e.lat = hit ? 1 : LAT; e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_valid(input string name);
        int w;
        w = 0;
        while (!out_valid && w < 30) begin
            tick(1);
            w++;
        end
        chk(name, 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 100) begin
            tick(1);
            w++;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        bit imm;
        logic [N-1:0]  hd;
        logic [RW-1:0] hr;
        rst_n = 1'b0; in_valid = 1'b0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0;
        in_rd = '0; flush = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_dbz", 64'(out_dbz), 64'd0);
        chk("rst_opcode", 64'(alu_opcode), 64'd0);
        chk("rst_rega", 64'(alu_rega), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Signed/unsigned div/rem, divide-by-zero, multiply variants
        out_ready = 1'b1;
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0, 1'b1, imm);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b1, imm);
        issue(3'b101, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, 1'b1, 1'b1, imm);
        issue(3'b111, 32'd5, 32'd0, 5'd6, 32'd5, 1'b1, 1'b1, imm);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, imm);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0, 1'b0, 1'b1, imm);
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h1, 1'b0, 1'b1, imm);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, 1'b0, 1'b1, imm);
        drain();

        // Backpressure in DONE, then back-to-back accept on drain
        out_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd4, 5'd8, 32'd12, 1'b0, 1'b1, imm);
        wait_valid("hold_reach_done");
        hd = out_data; hr = out_rd;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(hd));
            chk("hold_rd", 64'(out_rd), 64'(hr));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        issue(3'b011, 32'd3, 32'd4, 5'd9, 32'd0, 1'b0, 1'b1, imm);
        chk("b2b_immediate", 64'(imm), 64'd1);
        drain();

        // Flush during EXEC drops the result
        issue(3'b100, 32'd100, 32'd7, 5'd11, 32'd0, 1'b0, 1'b0, imm);
        chk("exec_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_exec_valid", 64'(out_valid), 64'd0);
        chk("flush_exec_busy", 64'(busy), 64'd0);
        tick(4);
        issue(3'b100, 32'd100, 32'd7, 5'd11, 32'd14, 1'b0, 1'b1, imm);
        drain();

        // Flush in DONE drops the pending result
        out_ready = 1'b0;
        issue(3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 1'b0, 1'b1, imm);
        wait_valid("flush_done_reach");
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        if (sbq.size() != 0) void'(sbq.pop_front());
        chk("flush_done_valid", 64'(out_valid), 64'd0);
        chk("flush_done_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        issue(3'b000, 32'd6, 32'd7, 5'd13, 32'd42, 1'b0, 1'b1, imm);
        drain();

        // Asynchronous reset in the middle of EXEC
        issue(3'b000, 32'd9, 32'd9, 5'd14, 32'd0, 1'b0, 1'b0, imm);
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_out_valid", 64'(out_valid), 64'd0);
        chk("amid_busy", 64'(busy), 64'd0);
        chk("amid_rega", 64'(alu_rega), 64'd0);
        chk("amid_regb", 64'(alu_regb), 64'd0);
        chk("amid_opcode", 64'(alu_opcode), 64'd0);
        chk("amid_out_data", 64'(out_data), 64'd0);
        chk("amid_out_rd", 64'(out_rd), 64'd0);
        have_last = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        issue(3'b000, 32'd9, 32'd9, 5'd14, 32'd81, 1'b0, 1'b1, imm);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Requester-side sequencer for the combinational M-extension mul/div unit (alu_muldiv).
- Accepts decoded MUL/DIV/REM instructions from decode over a valid/ready handshake.
- Encodes funct3 into the 5-bit mul/div ALU opcode and drives registered operands into the unit.
- Waits a fixed multicycle settle time, captures the result and divide-by-zero flag, and presents them to writeback over a second valid/ready handshake.

Parameters:
N, 32, datapath width (matches mul/div unit).
LAT, 2, settle cycles allowed for the combinational mul/div path; legal range 1..15.
RW, 5, destination register index width.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  decode presents an M instruction.
in_ready  out  1  controller can accept.
in_funct3  in  3  RISC-V funct3 of the M instruction.
in_rs1  in  N  operand A value.
in_rs2  in  N  operand B value.
in_rd  in  RW  destination register index.
alu_rega  out  N  registered operand A to mul/div unit.
alu_regb  out  N  registered operand B to mul/div unit.
alu_opcode  out  5  registered mul/div opcode.
alu_res_muldiv  in  N  result from mul/div unit.
flag_divbyzero  in  1  divide-by-zero flag from mul/div unit.
flush  in  1  synchronous pipeline kill.
out_valid  out  1  result available for writeback.
out_ready  in  1  writeback accepts.
out_data  out  N  captured result.
out_rd  out  RW  captured destination index.
out_dbz  out  1  captured divide-by-zero flag.
busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; alu_rega, alu_regb, out_data = 0; alu_opcode = 5'b00000 (non-muldiv, so unit output is 0); out_valid, out_dbz = 0; out_rd = 0; counter = 0.
- Reset asserted mid-operation aborts the operation immediately; no result is emitted.
- Opcode encoding (funct3 -> alu_opcode):
  - 000 MUL -> 01001
  - 001 MULH -> 01010
  - 010 MULHSU -> 01100
  - 011 MULHU -> 01011
  - 100 DIV -> 01101
  - 101 DIVU -> 01110
  - 110 REM -> 01111
  - 111 REMU -> 10000
- in_ready = (state==IDLE) | (state==DONE & out_ready); forced 0 while flush=1.
- Acceptance at edge k (in_valid & in_ready):
  - register operands, opcode and rd;
  - counter = LAT-1;
  - state -> EXEC.
- EXEC: counter decrements each cycle. When counter==0, the next edge captures alu_res_muldiv -> out_data and flag_divbyzero -> out_dbz, sets out_valid=1 and moves to DONE. out_valid is therefore first high after edge k+LAT.
- DONE: out_data, out_rd and out_dbz are held stable while out_valid=1 & out_ready=0.
  - out_ready=1 with no new accept: state -> IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept: state -> EXEC, out_valid=0 (back-to-back, no bubble on the input side).
- alu_rega, alu_regb and alu_opcode change only on acceptance, so the unit inputs stay stable for the full EXEC window (multicycle path constraint = LAT).
- flush (sync, highest priority after reset):
  - state -> IDLE, out_valid=0; the in-flight or pending result is dropped.
  - Any acceptance in the same cycle is suppressed.
  - Operand registers are not cleared.
- Only these signed/unsigned conventions apply; all arithmetic lives in the unit. The controller is width-transparent.

Optional Feature:
Macro MULDIV_OPERAND_REUSE_EN.
- Defined: a valid bit plus the last accepted rs1/rs2 are kept. A new acceptance with identical rs1 and rs2 (e.g. DIV followed by REM) sets counter=0, so the result is captured after exactly 1 EXEC cycle.
  - The reuse-valid bit is cleared by reset only. flush does not clear it, because the operand registers remain intact.
- Not defined: every operation takes LAT cycles; no comparator logic is present.

Decomposition:
- Shared package muldiv_pkg: the eight 5-bit opcode constants (MUL..REMU), the funct3 constants, and the state enum (IDLE, EXEC, DONE).
- One sub-module, muldiv_opc_enc: a combinational funct3 -> opcode encoder, reusable by the decode stage.
- Counter and FSM stay in the top module.

Test Plan:
- LAT=2. DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> out_data=0xFFFFFFFD, out_dbz=0, out_valid rises exactly 2 edges after accept. Then REM on the same operands -> 0xFFFFFFFF.
- DIVU rs1=5, rs2=0 -> out_data=0xFFFFFFFF, out_dbz=1. REMU rs1=5, rs2=0 -> out_data=5, out_dbz=1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH of the same operands -> 0x00000000. MUL -> 0x00000001.
- Hold out_ready=0 for 5 cycles in DONE -> out_data, out_rd and out_valid stay stable, in_ready=0. Then assert out_ready together with in_valid -> next op accepted on the same edge.
- flush during EXEC (and separately in DONE) -> out_valid never asserts for that op, state returns to IDLE, next op completes normally.
- With MULDIV_OPERAND_REUSE_EN: MUL 3×4 then MULHU 3×4 -> second result (0) valid 1 edge after accept. Without the macro it is valid after LAT edges. Also assert rst_n=0 mid-EXEC -> all outputs return to reset values asynchronously.
